// File: rtl/digital_stream_tx.sv
// Word FIFO: stores push data until the serializer fetches it.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: push_rdy low while full; pushes presented then are dropped.
module digital_stream_tx_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign push_rdy = (count_q != CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// Telemetry link transmitter: FIFO-buffered words serialized MSB-first on dCLK/dDAT/dFM.
// Latency: enable in IDLE -> first bit (dFM high) two cycles later; words back-to-back.
// Backpressure: ready = FIFO not full; empty FIFO at a word slot sends FILL_WORD. Macro PARITY_BIT_EN adds odd parity bit.
module digital_stream_tx #(
    parameter int                CLK_DIV     = 8,
    parameter int                WORD_W      = 12,
    parameter int                FRAME_WORDS = 16,
    parameter int                FIFO_DEPTH  = 8,
    parameter logic [WORD_W-1:0] FILL_WORD   = {WORD_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    input  logic              enable,
    output logic              dCLK,
    output logic              dDAT,
    output logic              dFM,
    output logic              wordSent,
    output logic              underrun,
    output logic              busy
);
`ifdef PARITY_BIT_EN
    localparam int NBITS = WORD_W + 1;
`else
    localparam int NBITS = WORD_W;
`endif
    localparam int PW  = $clog2(CLK_DIV);
    localparam int BCW = $clog2(NBITS);
    localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [PW-1:0]  PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]  PH_HALF  = PW'(CLK_DIV / 2);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(NBITS - 1);
    localparam logic [WCW-1:0] WORD_END = WCW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]    word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              dclk_q, dclk_d;
    logic              ddat_q, ddat_d;
    logic              dfm_q, dfm_d;
    logic              word_sent_q, word_sent_d;
    logic              underrun_q, underrun_d;
    logic              busy_q, busy_d;
`ifdef PARITY_BIT_EN
    logic              par_q, par_d;
`endif

    logic              fetch;
    logic              fill;
    logic [WCW-1:0]    word_nxt;
    logic              bit_out;
    logic              fm_out;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_head;

    // The empty test uses the registered count, so a word pushed in the
    // same cycle as an empty fetch waits for the next word slot.
    digital_stream_tx_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (valid),
        .push_dat (data),
        .push_rdy (ready),
        .pop      (fetch),
        .head_dat (fifo_head),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        fetch      = 1'b0;
        word_nxt   = (word_cnt_q == WORD_END) ? '0 : word_cnt_q + WCW'(1);

        case (state_q)
            ST_IDLE: begin
                phase_d   = '0;
                bit_cnt_d = '0;
                if (enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                fetch     = 1'b1;
                state_d   = ST_SHIFT;
                phase_d   = '0;
                bit_cnt_d = BIT_LAST;
            end
            ST_SHIFT: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_cnt_q != '0) begin
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q - BCW'(1);
                    end else begin
                        word_cnt_d = word_nxt;
                        // Stop only on a frame boundary; enable is ignored mid-frame.
                        if (!enable && (word_nxt == '0)) begin
                            state_d = ST_IDLE;
                        end else begin
                            fetch     = 1'b1;
                            bit_cnt_d = BIT_LAST;
                        end
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fill = fetch && fifo_empty;
        if (fetch) begin
            shift_d = fifo_empty ? FILL_WORD : fifo_head;
        end

        bit_out = shift_d[WORD_W-1];
`ifdef PARITY_BIT_EN
        par_d = par_q;
        if (fetch) begin
            par_d = ~^shift_d;
        end
        if (bit_cnt_d == '0) begin
            bit_out = par_d;
        end
`endif
        fm_out = (word_cnt_d == '0) && (bit_cnt_d == BIT_LAST);

        // Outputs are registered from next-state values so they line up with the state.
        dclk_d = (state_d == ST_SHIFT) && (phase_d >= PH_HALF);
        ddat_d = ddat_q;
        dfm_d  = dfm_q;
        if (state_d != ST_SHIFT) begin
            ddat_d = 1'b0;
            dfm_d  = 1'b0;
        end else if (phase_d == '0) begin
            ddat_d = bit_out;
            dfm_d  = fm_out;
        end
        word_sent_d = (state_d == ST_SHIFT) && (phase_d == PH_LAST) && (bit_cnt_d == '0);
        underrun_d  = fill;
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            shift_q     <= '0;
            dclk_q      <= 1'b0;
            ddat_q      <= 1'b0;
            dfm_q       <= 1'b0;
            word_sent_q <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PARITY_BIT_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            shift_q     <= shift_d;
            dclk_q      <= dclk_d;
            ddat_q      <= ddat_d;
            dfm_q       <= dfm_d;
            word_sent_q <= word_sent_d;
            underrun_q  <= underrun_d;
            busy_q      <= busy_d;
`ifdef PARITY_BIT_EN
            par_q       <= par_d;
`endif
        end
    end

    assign dCLK     = dclk_q;
    assign dDAT     = ddat_q;
    assign dFM      = dfm_q;
    assign wordSent = word_sent_q;
    assign underrun = underrun_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_digital_stream_tx.sv
// Directed bench for digital_stream_tx: a receiver model samples dDAT/dFM on dCLK rising edges.
module tb_digital_stream_tx;
    localparam int CLK_DIV     = 8;
    localparam int WORD_W      = 12;
    localparam int FRAME_WORDS = 4;
    localparam int FIFO_DEPTH  = 8;
`ifdef PARITY_BIT_EN
    localparam int NB = WORD_W + 1;
`else
    localparam int NB = WORD_W;
`endif
    localparam int WORD_CYC  = NB * CLK_DIV;
    localparam int FRAME_CYC = FRAME_WORDS * WORD_CYC;

    logic              clk    = 1'b0;
    logic              reset  = 1'b1;
    logic              valid  = 1'b0;
    logic              enable = 1'b0;
    logic [WORD_W-1:0] data   = '0;
    logic              ready, dCLK, dDAT, dFM, wordSent, underrun, busy;

    digital_stream_tx #(
        .CLK_DIV     (CLK_DIV),
        .WORD_W      (WORD_W),
        .FRAME_WORDS (FRAME_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .FILL_WORD   (12'h000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .enable   (enable),
        .dCLK     (dCLK),
        .dDAT     (dDAT),
        .dFM      (dFM),
        .wordSent (wordSent),
        .underrun (underrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int pc = 0;
    always @(posedge clk) pc <= pc + 1;

    logic bitq[$];
    logic fmq[$];
    int   riseq[$];
    int   wsq[$];
    int   ur_cnt = 0;
    logic dclk_prev = 1'b0;

    always @(negedge clk) begin
        if (dCLK && !dclk_prev) begin
            bitq.push_back(dDAT);
            fmq.push_back(dFM);
            riseq.push_back(pc);
        end
        dclk_prev = dCLK;
        if (wordSent) wsq.push_back(pc);
        if (underrun) ur_cnt++;
    end

    typedef struct {
        logic [WORD_W-1:0] word;
        logic [WORD_W-1:0] exp_bits;
        logic              exp_par;
        logic              exp_rdy;
    } vec_t;

    vec_t tbl[8];
    vec_t t2;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WORD_W-1:0] w);
        int n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        if (!ready) chk("push_ready_timeout", {31'b0, ready}, 1);
        valid = 1'b1;
        data  = w;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_ws(input string nm, input int n, input int budget);
        int k = 0;
        while (wsq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, {31'b0, wsq.size() >= n}, 1);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        chk(nm, {31'b0, busy}, 0);
    endtask

    function automatic int rise_at(input int i);
        return (i < riseq.size()) ? riseq[i] : -1;
    endfunction

    function automatic int ws_at(input int i);
        return (i < wsq.size()) ? wsq[i] : -1;
    endfunction

    function automatic logic fm_at(input int i);
        return (i < fmq.size()) ? fmq[i] : 1'bx;
    endfunction

    task automatic get_word(input int idx, output logic [WORD_W-1:0] w, output logic p);
        w = 'x;
        p = 1'bx;
        if (idx + NB <= bitq.size()) begin
            for (int k = 0; k < WORD_W; k++) w[WORD_W-1-k] = bitq[idx+k];
`ifdef PARITY_BIT_EN
            p = bitq[idx+WORD_W];
`else
            p = 1'b0;
`endif
        end
    endtask

    function automatic int fm_count(input int from, input int len);
        int c = 0;
        for (int k = 0; k < len; k++) if (fm_at(from + k) !== 1'b0) c++;
        return c;
    endfunction

    function automatic int spacing_bad(input int from, input int len);
        int c = 0;
        for (int k = 1; k < len; k++)
            if (rise_at(from + k) - rise_at(from + k - 1) != CLK_DIV) c++;
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, r0, w0, u0, en_pc, bad, n;
        logic [WORD_W-1:0] w, orw;
        logic p;
        logic [31:0] fmv;

        tbl[0] = '{12'h001, 12'b0000_0000_0001, 1'b0, 1'b1};
        tbl[1] = '{12'h003, 12'b0000_0000_0011, 1'b1, 1'b1};
        tbl[2] = '{12'h800, 12'b1000_0000_0000, 1'b0, 1'b1};
        tbl[3] = '{12'h7FF, 12'b0111_1111_1111, 1'b0, 1'b1};
        tbl[4] = '{12'h123, 12'b0001_0010_0011, 1'b1, 1'b1};
        tbl[5] = '{12'hABC, 12'b1010_1011_1100, 1'b0, 1'b1};
        tbl[6] = '{12'h555, 12'b0101_0101_0101, 1'b1, 1'b1};
        tbl[7] = '{12'hE0F, 12'b1110_0000_1111, 1'b0, 1'b0};
        t2     = '{12'hA5C, 12'b1010_0101_1100, 1'b1, 1'b1};

        // Reset state, then asynchronous reset in phase 3 of the first bit.
        repeat (3) tick();
        chk("rst_outputs", {26'b0, dCLK, dDAT, dFM, wordSent, underrun, busy}, 0);
        chk("rst_ready", {31'b0, ready}, 1);
        reset = 1'b0;
        tick();
        push(12'hFFF);
        push(12'hFFF);
        enable = 1'b1;
        n = 0;
        while (!dFM && n < 20) begin
            tick();
            n++;
        end
        chk("t1_first_bit_fm", {31'b0, dFM}, 1);
        repeat (3) tick();
        chk("t1_pre_reset", {28'b0, busy, dDAT, dFM, dCLK}, 32'b1110);
        reset = 1'b1;
        #1;
        chk("t1_async_rst", {26'b0, dCLK, dDAT, dFM, wordSent, underrun, busy}, 0);
        chk("t1_rst_ready", {31'b0, ready}, 1);
        enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        bad = 0;
        repeat (40) begin
            tick();
            if ({dCLK, dDAT, dFM, wordSent, underrun, busy} != 6'b0) bad++;
        end
        chk("t1_quiet_after_rst", bad, 0);

        // Single word 0xA5C: timing, bit order, marker, wordSent position.
        b0 = bitq.size(); r0 = riseq.size(); w0 = wsq.size(); u0 = ur_cnt;
        push(t2.word);
        enable = 1'b1;
        en_pc  = pc;
        tick();
        enable = 1'b0;
        wait_idle("t2_idle_timeout", FRAME_CYC + 50);
        chk("t2_rise_count", riseq.size() - r0, FRAME_WORDS * NB);
        chk("t2_first_rise", rise_at(r0) - en_pc, 6);
        chk("t2_bit_spacing", spacing_bad(r0, FRAME_WORDS * NB), 0);
        get_word(b0, w, p);
        chk("t2_word", {20'b0, w}, {20'b0, t2.exp_bits});
`ifdef PARITY_BIT_EN
        chk("t2_parity", {31'b0, p}, {31'b0, t2.exp_par});
`endif
        fmv = 0;
        for (int k = 0; k < NB; k++) fmv = {fmv[30:0], fm_at(b0 + k)};
        chk("t2_fm_word0", fmv, 32'(1) << (NB - 1));
        chk("t2_fm_count", fm_count(b0, FRAME_WORDS * NB), 1);
        chk("t2_wordsent_time", ws_at(w0) - en_pc, 1 + WORD_CYC);
        chk("t2_wordsent_count", wsq.size() - w0, FRAME_WORDS);
        chk("t2_underruns", ur_cnt - u0, FRAME_WORDS - 1);

        // Table: fill the FIFO, ninth push refused, enable toggled mid-frame.
        b0 = bitq.size(); r0 = riseq.size(); w0 = wsq.size(); u0 = ur_cnt;
        for (int i = 0; i < 8; i++) begin
            push(tbl[i].word);
            chk($sformatf("t4_ready_%0d", i), {31'b0, ready}, {31'b0, tbl[i].exp_rdy});
        end
        valid = 1'b1;
        data  = 12'hFFF;
        chk("t4_ninth_blocked", {31'b0, ready}, 0);
        tick();
        valid = 1'b0;
        enable = 1'b1;
        wait_ws("t4_ws1_timeout", w0 + 1, WORD_CYC + 20);
        enable = 1'b0;
        wait_ws("t4_ws2_timeout", w0 + 2, WORD_CYC + 20);
        enable = 1'b1;
        wait_ws("t4_ws5_timeout", w0 + 5, 3 * WORD_CYC + 20);
        enable = 1'b0;
        wait_idle("t4_idle_timeout", 4 * WORD_CYC + 50);
        for (int i = 0; i < 8; i++) begin
            get_word(b0 + i * NB, w, p);
            chk($sformatf("t4_word_%0d", i), {20'b0, w}, {20'b0, tbl[i].exp_bits});
`ifdef PARITY_BIT_EN
            chk($sformatf("t4_parity_%0d", i), {31'b0, p}, {31'b0, tbl[i].exp_par});
`endif
        end
        chk("t4_wordsent_count", wsq.size() - w0, 8);
        chk("t4_underruns", ur_cnt - u0, 0);
        chk("t4_bit_spacing", spacing_bad(r0, 8 * NB), 0);
        chk("t4_fm_count", fm_count(b0, 8 * NB), 2);
        chk("t4_fm_frame1", {31'b0, fm_at(b0 + FRAME_WORDS * NB)}, 1);

        // Empty FIFO: fill words with one underrun each, marker every frame.
        b0 = bitq.size(); w0 = wsq.size(); u0 = ur_cnt;
        enable = 1'b1;
        wait_ws("t3_ws5_timeout", w0 + 5, 6 * WORD_CYC);
        enable = 1'b0;
        wait_idle("t3_idle_timeout", 4 * WORD_CYC + 50);
        chk("t3_wordsent_count", wsq.size() - w0, 8);
        chk("t3_underruns", ur_cnt - u0, 8);
        orw = '0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            get_word(b0 + i * NB, w, p);
            orw = orw | w;
            if (p !== 1'b1) bad++;
        end
        chk("t3_fill_data", {20'b0, orw}, 0);
`ifdef PARITY_BIT_EN
        chk("t3_fill_parity", bad, 0);
`endif
        chk("t3_fm_first", {31'b0, fm_at(b0)}, 1);
        chk("t3_fm_second", {31'b0, fm_at(b0 + FRAME_WORDS * NB)}, 1);
        chk("t3_fm_count", fm_count(b0, 8 * NB), 2);

        // Enable dropped during word 1: frame finishes, then quiet IDLE.
        b0 = bitq.size(); r0 = riseq.size(); w0 = wsq.size(); u0 = ur_cnt;
        for (int i = 4; i < 8; i++) push(tbl[i].word);
        enable = 1'b1;
        wait_ws("t5_ws1_timeout", w0 + 1, WORD_CYC + 20);
        repeat (20) tick();
        enable = 1'b0;
        wait_idle("t5_idle_timeout", 3 * WORD_CYC + 50);
        chk("t5_wordsent_count", wsq.size() - w0, FRAME_WORDS);
        chk("t5_rise_count", riseq.size() - r0, FRAME_WORDS * NB);
        chk("t5_underruns", ur_cnt - u0, 0);
        chk("t5_fm_first", {31'b0, fm_at(b0)}, 1);
        for (int i = 0; i < 4; i++) begin
            get_word(b0 + i * NB, w, p);
            chk($sformatf("t5_word_%0d", i), {20'b0, w}, {20'b0, tbl[4+i].exp_bits});
        end
        bad = 0;
        repeat (30) begin
            tick();
            if (dCLK || busy || dDAT || dFM) bad++;
        end
        chk("t5_idle_quiet", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
